// File: rtl/pipe_stage_hs.sv
// Generic valid/ready pipeline register carrying an opaque payload between stages,
// with flush-to-bubble, optional 2-entry skid mode and a discarded-beat counter.
module pipe_stage_hs #(
    parameter int unsigned    DW     = 128,
    parameter logic [DW-1:0]  BUBBLE = {DW{1'b0}},
    parameter bit             SKID   = 1'b1,
    parameter int unsigned    CW     = 16
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occupancy,
    output logic [CW-1:0] flush_cnt
);

    logic          m_valid_q, m_valid_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          s_valid_q, s_valid_d;
    logic [DW-1:0] s_data_q, s_data_d;
    logic          rdy_q, rdy_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;

    logic          pop;
    logic          acc;
    logic [1:0]    drop;
    logic [CW:0]   cnt_sum;

    assign pop       = m_valid_q & out_ready;
    assign in_ready  = SKID ? rdy_q : (~m_valid_q | out_ready);
    assign acc       = in_valid & in_ready;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
    assign flush_cnt = flush_cnt_q;

    // A beat popping on the flush edge was delivered, so it is not counted.
    assign drop    = {1'b0, m_valid_q & ~pop} + {1'b0, s_valid_q};
    assign cnt_sum = {1'b0, flush_cnt_q} + (CW+1)'(drop);

    always_comb begin
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        s_valid_d   = s_valid_q;
        s_data_d    = s_data_q;
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            m_valid_d   = 1'b0;
            m_data_d    = BUBBLE;
            s_valid_d   = 1'b0;
            s_data_d    = BUBBLE;
            flush_cnt_d = cnt_sum[CW] ? {CW{1'b1}} : cnt_sum[CW-1:0];
        end else if (!SKID) begin
            if (acc) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
            end else if (pop) begin
                m_valid_d = 1'b0;
                m_data_d  = BUBBLE;
            end
        end else if (pop) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
                s_data_d  = BUBBLE;
            end else if (acc) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
            end else begin
                m_valid_d = 1'b0;
                m_data_d  = BUBBLE;
            end
        end else if (acc) begin
            if (!m_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
            end else begin
                s_valid_d = 1'b1;
                s_data_d  = in_data;
            end
        end
        rdy_d = ~s_valid_d;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_valid_q   <= 1'b0;
            m_data_q    <= BUBBLE;
            s_valid_q   <= 1'b0;
            s_data_q    <= BUBBLE;
            rdy_q       <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            s_valid_q   <= s_valid_d;
            s_data_q    <= s_data_d;
            rdy_q       <= rdy_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: skid (BUBBLE=3), non-skid, and CW=2 instances.
module tb_pipe_stage_hs;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic         a_iv, a_ir, a_fl, a_ov, a_or;
    logic [127:0] a_id, a_od;
    logic [1:0]   a_oc;
    logic [15:0]  a_fc;

    logic         b_iv, b_ir, b_fl, b_ov, b_or;
    logic [127:0] b_id, b_od;
    logic [1:0]   b_oc;
    logic [15:0]  b_fc;

    logic         c_iv, c_ir, c_fl, c_ov, c_or;
    logic [127:0] c_id, c_od;
    logic [1:0]   c_oc;
    logic [1:0]   c_fc;

    pipe_stage_hs #(.DW(128), .BUBBLE(128'h3), .SKID(1'b1), .CW(16)) u_a (
        .CLK(CLK), .RSTN(RSTN), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .flush(a_fl), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .occupancy(a_oc), .flush_cnt(a_fc));

    pipe_stage_hs #(.DW(128), .BUBBLE(128'h0), .SKID(1'b0), .CW(16)) u_b (
        .CLK(CLK), .RSTN(RSTN), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .flush(b_fl), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .occupancy(b_oc), .flush_cnt(b_fc));

    pipe_stage_hs #(.DW(128), .BUBBLE(128'h0), .SKID(1'b1), .CW(2)) u_c (
        .CLK(CLK), .RSTN(RSTN), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
        .flush(c_fl), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
        .occupancy(c_oc), .flush_cnt(c_fc));

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        {a_iv, a_fl, a_or, b_iv, b_fl, b_or, c_iv, c_fl, c_or} = '0;
        a_id = '0; b_id = '0; c_id = '0;
        RSTN = 1'b0;
        tick();
        checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL rst_a_ov got %0h want 0", a_ov); end
        checks++; if (a_od !== 128'h3) begin errors++; $display("FAIL rst_a_od got %0h want 3", a_od); end
        checks++; if (a_oc !== 2'd0) begin errors++; $display("FAIL rst_a_occ got %0d want 0", a_oc); end
        checks++; if (a_fc !== 16'd0) begin errors++; $display("FAIL rst_a_fc got %0d want 0", a_fc); end
        checks++; if (a_ir !== 1'b0) begin errors++; $display("FAIL rst_a_ir got %0h want 0", a_ir); end
        checks++; if (b_ir !== 1'b1) begin errors++; $display("FAIL rst_b_ir got %0h want 1", b_ir); end
        checks++; if (b_od !== 128'h0) begin errors++; $display("FAIL rst_b_od got %0h want 0", b_od); end
        RSTN = 1'b1;
        #1;
        checks++; if (a_ir !== 1'b0) begin errors++; $display("FAIL rel_a_ir got %0h want 0", a_ir); end
        tick();
        checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL rel1_a_ir got %0h want 1", a_ir); end
        checks++; if (c_ir !== 1'b1) begin errors++; $display("FAIL rel1_c_ir got %0h want 1", c_ir); end
    endtask

    task automatic test_stream();
        a_or = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL str_ir[%0d] got %0h want 1", i, a_ir); end
            a_iv = 1'b1;
            a_id = 128'(i);
            tick();
            checks++; if (a_ov !== 1'b1 || a_od !== 128'(i)) begin errors++; $display("FAIL str_out[%0d] got v=%0h d=%0h want v=1 d=%0h", i, a_ov, a_od, i); end
            checks++; if (a_oc !== 2'd1) begin errors++; $display("FAIL str_occ[%0d] got %0d want 1", i, a_oc); end
        end
        a_iv = 1'b0;
        tick();
        checks++; if (a_ov !== 1'b0 || a_od !== 128'h3) begin errors++; $display("FAIL str_end got v=%0h d=%0h want v=0 d=3", a_ov, a_od); end
    endtask

    task automatic test_backpressure();
        int ir_t[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        int ov_t[10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int od_t[10] = '{3, 1, 2, 2, 2, 3, 4, 5, 6, 3};
        int oc_t[10] = '{0, 1, 1, 2, 2, 1, 1, 1, 1, 0};
        int or_t[10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        int iv_t[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
        int nxt = 1;
        for (int c = 0; c < 10; c++) begin
            checks++; if (a_ir !== 1'(ir_t[c])) begin errors++; $display("FAIL bp_ir[%0d] got %0h want %0d", c, a_ir, ir_t[c]); end
            checks++; if (a_ov !== 1'(ov_t[c]) || a_od !== 128'(od_t[c])) begin errors++; $display("FAIL bp_out[%0d] got v=%0h d=%0h want v=%0d d=%0h", c, a_ov, a_od, ov_t[c], od_t[c]); end
            checks++; if (a_oc !== 2'(oc_t[c])) begin errors++; $display("FAIL bp_occ[%0d] got %0d want %0d", c, a_oc, oc_t[c]); end
            a_or = 1'(or_t[c]);
            a_iv = 1'(iv_t[c]);
            a_id = 128'(nxt);
            if (iv_t[c] != 0) nxt++;
            tick();
        end
        a_iv = 1'b0;
    endtask

    task automatic test_flush_bubble();
        a_or = 1'b0;
        a_iv = 1'b1; a_id = 128'hA;
        tick();
        a_id = 128'hB;
        tick();
        checks++; if (a_oc !== 2'd2 || a_ir !== 1'b0) begin errors++; $display("FAIL fl_full got occ=%0d ir=%0h want occ=2 ir=0", a_oc, a_ir); end
        a_id = 128'hC; a_fl = 1'b1;
        tick();
        a_fl = 1'b0; a_iv = 1'b0;
        checks++; if (a_ov !== 1'b0 || a_od !== 128'h3) begin errors++; $display("FAIL fl_bub got v=%0h d=%0h want v=0 d=3", a_ov, a_od); end
        checks++; if (a_fc !== 16'd2) begin errors++; $display("FAIL fl_cnt got %0d want 2", a_fc); end
        checks++; if (a_oc !== 2'd0 || a_ir !== 1'b1) begin errors++; $display("FAIL fl_post got occ=%0d ir=%0h want occ=0 ir=1", a_oc, a_ir); end
        a_or = 1'b1;
        tick();
        checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL fl_noC got v=%0h d=%0h want v=0", a_ov, a_od); end
    endtask

    task automatic test_flush_pop();
        a_or = 1'b1; a_iv = 1'b1; a_id = 128'h5;
        tick();
        checks++; if (a_ov !== 1'b1 || a_od !== 128'h5) begin errors++; $display("FAIL fp_m got v=%0h d=%0h want v=1 d=5", a_ov, a_od); end
        a_id = 128'h9; a_fl = 1'b1;
        tick();
        a_fl = 1'b0; a_iv = 1'b0;
        checks++; if (a_fc !== 16'd2) begin errors++; $display("FAIL fp_cnt got %0d want 2", a_fc); end
        checks++; if (a_ov !== 1'b0 || a_od !== 128'h3) begin errors++; $display("FAIL fp_bub got v=%0h d=%0h want v=0 d=3", a_ov, a_od); end
        tick();
        checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL fp_drop9 got v=%0h d=%0h want v=0", a_ov, a_od); end
    endtask

    task automatic test_noskid();
        b_iv = 1'b1; b_id = 128'h7; b_or = 1'b0;
        #1;
        checks++; if (b_ir !== 1'b1) begin errors++; $display("FAIL ns_ir_empty got %0h want 1", b_ir); end
        tick();
        b_iv = 1'b0;
        #1;
        checks++; if (b_ir !== 1'b0) begin errors++; $display("FAIL ns_ir_stall got %0h want 0", b_ir); end
        checks++; if (b_ov !== 1'b1 || b_od !== 128'h7) begin errors++; $display("FAIL ns_m7 got v=%0h d=%0h want v=1 d=7", b_ov, b_od); end
        b_or = 1'b1; b_iv = 1'b1; b_id = 128'h8;
        #1;
        checks++; if (b_ir !== 1'b1) begin errors++; $display("FAIL ns_ir_comb got %0h want 1", b_ir); end
        tick();
        b_iv = 1'b0;
        checks++; if (b_ov !== 1'b1 || b_od !== 128'h8 || b_oc !== 2'd1) begin errors++; $display("FAIL ns_m8 got v=%0h d=%0h occ=%0d want v=1 d=8 occ=1", b_ov, b_od, b_oc); end
        tick();
        checks++; if (b_ov !== 1'b0 || b_od !== 128'h0 || b_oc !== 2'd0) begin errors++; $display("FAIL ns_empty got v=%0h d=%0h occ=%0d want v=0 d=0 occ=0", b_ov, b_od, b_oc); end
    endtask

    task automatic test_saturate_and_reset();
        logic [1:0] exp;
        c_or = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            c_iv = 1'b1; c_id = 128'(k); c_fl = 1'b0;
            tick();
            c_iv = 1'b0; c_fl = 1'b1;
            tick();
            c_fl = 1'b0;
            exp = (k > 3) ? 2'd3 : 2'(k);
            checks++; if (c_fc !== exp) begin errors++; $display("FAIL sat_cnt[%0d] got %0d want %0d", k, c_fc, exp); end
        end
        c_iv = 1'b1; c_id = 128'h44;
        tick();
        c_iv = 1'b0;
        checks++; if (c_ov !== 1'b1 || c_oc !== 2'd1) begin errors++; $display("FAIL mid_pre got v=%0h occ=%0d want v=1 occ=1", c_ov, c_oc); end
        RSTN = 1'b0;
        #1;
        checks++; if (c_ov !== 1'b0 || c_od !== 128'h0 || c_oc !== 2'd0) begin errors++; $display("FAIL mid_rst got v=%0h d=%0h occ=%0d want 0", c_ov, c_od, c_oc); end
        checks++; if (c_fc !== 2'd0 || c_ir !== 1'b0) begin errors++; $display("FAIL mid_rst_fc got fc=%0d ir=%0h want fc=0 ir=0", c_fc, c_ir); end
        checks++; if (a_fc !== 16'd0) begin errors++; $display("FAIL mid_rst_afc got %0d want 0", a_fc); end
        RSTN = 1'b1;
        tick();
        checks++; if (c_ir !== 1'b1 || c_ov !== 1'b0) begin errors++; $display("FAIL mid_rel got ir=%0h v=%0h want ir=1 v=0", c_ir, c_ov); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_bubble();
        test_flush_pop();
        test_noskid();
        test_saturate_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
